// File: rtl/decoder_pipe_if.sv
// decoder_pipe_if: handshake bundle between a decode producer and decoder_pipe
// Ports (slave view = decoder_pipe):
//   w, en, mode, in_valid  -> select word and its valid; in_ready <- accept
//   sweep_start            -> one-cycle sweep request; sweep_busy <- sweep running
//   out, out_valid         <- decoded word; out_ready -> consumer takes it
interface decoder_pipe_if #(parameter int W = 4);
    localparam int N = 1 << W;
    logic [W-1:0] w;
    logic en, mode, in_valid, in_ready, sweep_start, sweep_busy, out_valid, out_ready;
    logic [N-1:0] out;
    modport master (output w, en, mode, in_valid, sweep_start, out_ready,
                    input in_ready, sweep_busy, out, out_valid);
    modport slave (input w, en, mode, in_valid, sweep_start, out_ready,
                   output in_ready, sweep_busy, out, out_valid);
endinterface

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered W-to-2^W one-hot/thermometer decoder with a sweep mode
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    decoder_pipe_if.slave: w/en/mode/in_valid/in_ready input handshake,
//          sweep_start/sweep_busy sweep control, out/out_valid/out_ready output handshake
module decoder_pipe #(parameter int W = 4) (
    input logic clk,
    input logic rst_n,
    decoder_pipe_if.slave bus
);
    localparam int N = 1 << W;
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t state, state_nx;
    logic [W-1:0] cnt, cnt_nx;
    logic [N-1:0] out_q, out_nx;
    logic valid_q, valid_nx, slot_free, accept, last;
    assign slot_free = !valid_q || bus.out_ready;
    assign bus.in_ready = state == IDLE && !bus.sweep_start && slot_free;
    assign accept = bus.in_valid && bus.in_ready;
    assign bus.sweep_busy = state == SWEEP;
    assign bus.out = out_q;
    assign bus.out_valid = valid_q;
    assign last = cnt == W'(N - 1);
    // A consume clears valid; any load below overrides it in the same cycle.
    // Thermometer: shifting all-ones right by (N-1-w), which is ~w in W bits.
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        out_nx = out_q;
        valid_nx = valid_q && !bus.out_ready;
        if (state == IDLE) begin
            if (bus.sweep_start) begin
                state_nx = SWEEP;
                cnt_nx = '0;
            end else if (accept) begin
                out_nx = !bus.en ? '0 : bus.mode ? {N{1'b1}} >> ~bus.w : N'(1) << bus.w;
                valid_nx = 1'b1;
            end
        end else if (slot_free) begin
            out_nx = N'(1) << cnt;
            valid_nx = 1'b1;
            state_nx = last ? IDLE : SWEEP;
            cnt_nx = last ? '0 : cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            out_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            out_q <= out_nx;
            valid_q <= valid_nx;
        end
    end
endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: scoreboard bench for decoder_pipe (W=4)
module tb_decoder_pipe;
    localparam int W = 4;
    localparam int N = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    decoder_pipe_if #(.W(W)) bus();
    decoder_pipe #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0;
    int fails = 0;
    int words = 0;
    logic [N-1:0] sb[$];
    function automatic logic [N-1:0] model(input logic [W-1:0] a, input logic e, input logic m);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = e && (m ? i <= int'(a) : i == int'(a));
        return r;
    endfunction
    // Consumed words are compared first, then newly accepted inputs are queued.
    always @(negedge clk) begin
        logic [N-1:0] e;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                words++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL word: got unexpected out=%h, no word required", bus.out);
                end else begin
                    e = sb.pop_front();
                    if (bus.out !== e) begin
                        fails++;
                        $display("FAIL word: got out=%h, want %h", bus.out, e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.w, bus.en, bus.mode));
        end
    end
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    task automatic push_sweep;
        for (int k = 0; k < N; k++) sb.push_back(model(W'(k), 1'b1, 1'b0));
    endtask
    task automatic test_reset;
        bus.w = '0; bus.en = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0;
        bus.sweep_start = 1'b0; bus.out_ready = 1'b0;
        #2;
        checks++;
        if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0 || bus.sweep_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got out=%h valid=%b busy=%b, want 0000 0 0", bus.out, bus.out_valid, bus.sweep_busy);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        bus.sweep_start = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_ready_sweep: got %b want 0", bus.in_ready);
        end
        bus.sweep_start = 1'b0;
        cyc;
        rst_n = 1'b1;
        cyc;
    endtask
    task automatic test_onehot;
        bus.w = 4'hF; bus.en = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL onehot_in_ready: got %b want 1", bus.in_ready);
        end
        cyc;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out !== 16'h8000 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL onehot_out: got out=%h valid=%b, want 8000 1", bus.out, bus.out_valid);
        end
        cyc;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL onehot_drain: got valid=%b want 0", bus.out_valid);
        end
    endtask
    task automatic test_thermo_enable;
        bus.w = 4'd3; bus.en = 1'b1; bus.mode = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        cyc;
        bus.mode = 1'b0; bus.en = 1'b0;
        checks++;
        if (bus.out !== 16'h000F || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL thermo_out: got out=%h valid=%b, want 000f 1", bus.out, bus.out_valid);
        end
        cyc;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out !== 16'h0000 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL enable_zero: got out=%h valid=%b, want 0000 1", bus.out, bus.out_valid);
        end
        bus.w = 4'd9; bus.en = 1'b1; bus.mode = 1'b1; bus.in_valid = 1'b1;
        cyc;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out !== 16'h03FF) begin
            fails++;
            $display("FAIL thermo_9: got out=%h want 03ff", bus.out);
        end
        cyc;
    endtask
    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        bus.w = 4'd1; bus.en = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b1;
        cyc;
        bus.w = 4'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.out !== 16'h0002 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold: got out=%h valid=%b in_ready=%b, want 0002 1 0", bus.out, bus.out_valid, bus.in_ready);
            end
            cyc;
        end
        bus.out_ready = 1'b1;
        cyc;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out !== 16'h0004 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_next: got out=%h valid=%b, want 0004 1", bus.out, bus.out_valid);
        end
        cyc;
        checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: got pending=%0d valid=%b, want 0 0", sb.size(), bus.out_valid);
        end
    endtask
    task automatic test_sweep;
        logic [N-1:0] e;
        int busy_n;
        bus.out_ready = 1'b1; bus.sweep_start = 1'b1;
        push_sweep();
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL sweep_start_in_ready: got %b want 0", bus.in_ready);
        end
        cyc;
        bus.sweep_start = 1'b0;
        bus.w = 4'd5; bus.en = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.sweep_busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL sweep_enter: got busy=%b in_ready=%b, want 1 0", bus.sweep_busy, bus.in_ready);
        end
        busy_n = 1;
        for (int k = 0; k < N; k++) begin
            cyc;
            e = '0;
            e[k] = 1'b1;
            checks++;
            if (bus.out !== e || bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL sweep_code%0d: got out=%h valid=%b, want %h 1", k, bus.out, bus.out_valid, e);
            end
            checks++;
            if (bus.in_ready !== (k == N - 1)) begin
                fails++;
                $display("FAIL sweep_in_ready%0d: got %b want %b", k, bus.in_ready, k == N - 1);
            end
            if (bus.sweep_busy) busy_n++;
        end
        checks++;
        if (busy_n != N) begin
            fails++;
            $display("FAIL sweep_busy_len: got %0d cycles want %0d", busy_n, N);
        end
        cyc;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out !== 16'h0020) begin
            fails++;
            $display("FAIL sweep_after_input: got out=%h want 0020", bus.out);
        end
        cyc;
    endtask
    task automatic test_sweep_stall;
        int w0, n;
        bus.out_ready = 1'b1;
        bus.w = 4'd7; bus.en = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b1; bus.sweep_start = 1'b1;
        push_sweep();
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL collide_in_ready: got %b want 0", bus.in_ready);
        end
        w0 = words;
        cyc;
        bus.sweep_start = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.sweep_busy !== 1'b1) begin
            fails++;
            $display("FAIL collide_busy: got %b want 1", bus.sweep_busy);
        end
        n = 0;
        while ((bus.sweep_busy || sb.size() != 0) && n < 300) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.sweep_start = (n == 6);
            cyc;
            n++;
        end
        bus.sweep_start = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) cyc;
        checks++;
        if (n >= 300) begin
            fails++;
            $display("FAIL stall_timeout: got %0d cycles, want under 300", n);
        end
        checks++;
        if (words - w0 != N || bus.sweep_busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_words: got %0d words busy=%b valid=%b, want %0d 0 0", words - w0, bus.sweep_busy, bus.out_valid, N);
        end
    endtask
    task automatic test_reset_mid_sweep;
        int n, w1;
        logic bad;
        bus.out_ready = 1'b1; bus.sweep_start = 1'b1;
        push_sweep();
        cyc;
        bus.sweep_start = 1'b0;
        n = 0;
        while (bus.out !== 16'h0020 && n < 40) begin
            cyc;
            n++;
        end
        checks++;
        if (n >= 40) begin
            fails++;
            $display("FAIL rst_wait: got out=%h, want 0020 within 40 cycles", bus.out);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0 || bus.sweep_busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: got out=%h valid=%b busy=%b, want 0000 0 0", bus.out, bus.out_valid, bus.sweep_busy);
        end
        sb.delete();
        cyc;
        rst_n = 1'b1;
        w1 = words;
        bad = 1'b0;
        repeat (20) begin
            cyc;
            if (bus.out_valid !== 1'b0 || bus.sweep_busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || words != w1) begin
            fails++;
            $display("FAIL rst_no_resume: got activity=%b words=%0d, want 0 0", bad, words - w1);
        end
        bus.w = 4'd0; bus.en = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b1;
        cyc;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out !== 16'h0001 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_then_input: got out=%h valid=%b, want 0001 1", bus.out, bus.out_valid);
        end
        cyc;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL final_pending: got %0d words left, want 0", sb.size());
        end
    endtask
    initial begin
        test_reset();
        test_onehot();
        test_thermo_enable();
        test_backpressure();
        test_sweep();
        test_sweep_stall();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
